// File: rtl/bank_axi3_pkg.sv
// Shared definitions for the bank AXI3 responder memory.
// Contents: AXI response / size / burst encodings, read and write FSM state
// enums, and the response-merge helper that keeps the worst error of a burst.
package bank_axi3_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] SIZE_32B    = 3'b101;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

  // The encodings are ordered by severity (OKAY < SLVERR < DECERR), so the
  // worse of two responses is simply the numerically larger one.
  function automatic logic [1:0] resp_merge(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bank_slv_mem_array.sv
// Line storage for the AXI3 responder: DEPTH x DATA_WIDTH lines.
// Ports:
//   clk_i, rst_i        clock, async active-high reset (read register only)
//   we_i/waddr_i        write enable and line index
//   wdata_i/wstrb_i     write line data and per-byte enables
//   re_i/raddr_i        read enable and line index (synchronous read)
//   rdata_o             registered read data, holds until the next re_i
// A read and a write to the same line on one edge return the pre-write data.
module bank_slv_mem_array #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; that is also what makes the read port read-before-write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  // NOTE: the storage array has no reset; resetting a RAM would stop it mapping
  // onto block memory and its contents are meaningless until written anyway.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bank_axi3_slv_mem.sv
// AXI3 responder terminating the bank BIU master port, backed by a line array.
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   s_ar*/s_r*                   read address / read data channels
//   s_aw*/s_w*/s_b*              write address / write data / write response
// Read and write paths are independent FSMs with one outstanding burst each.
// Only 32-byte INCR bursts are served; other size/burst -> SLVERR on every
// beat. Beats whose line index is >= DEPTH get DECERR and never touch memory.
module bank_axi3_slv_mem
  import bank_axi3_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 6,
  parameter int DEPTH      = 1024,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  s_arvalid_i,
  output logic                  s_arready_o,
  input  logic [ID_WIDTH-1:0]   s_arid_i,
  input  logic [ADDR_WIDTH-1:0] s_araddr_i,
  input  logic [3:0]            s_arlen_i,
  input  logic [2:0]            s_arsize_i,
  input  logic [1:0]            s_arburst_i,
  output logic                  s_rvalid_o,
  input  logic                  s_rready_i,
  output logic [ID_WIDTH-1:0]   s_rid_o,
  output logic [DATA_WIDTH-1:0] s_rdata_o,
  output logic [1:0]            s_rresp_o,
  output logic                  s_rlast_o,
  input  logic                  s_awvalid_i,
  output logic                  s_awready_o,
  input  logic [ID_WIDTH-1:0]   s_awid_i,
  input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
  input  logic [3:0]            s_awlen_i,
  input  logic [2:0]            s_awsize_i,
  input  logic [1:0]            s_awburst_i,
  input  logic                  s_wvalid_i,
  output logic                  s_wready_o,
  input  logic [ID_WIDTH-1:0]   s_wid_i,
  input  logic [DATA_WIDTH-1:0] s_wdata_i,
  input  logic [STRB_WIDTH-1:0] s_wstrb_i,
  input  logic                  s_wlast_i,
  output logic                  s_bvalid_o,
  input  logic                  s_bready_i,
  output logic [ID_WIDTH-1:0]   s_bid_o,
  output logic [1:0]            s_bresp_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LINE_W = ADDR_WIDTH - 5;
  localparam int CNT_W = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 2);

  // Line index is never wrapped, so anything past the array decode-errors.
  function automatic logic [1:0] line_resp(input logic [LINE_W-1:0] line);
    return (line >= LINE_W'(DEPTH)) ? RESP_DECERR : RESP_OKAY;
  endfunction

  // Byte offset within a line carries no information for full-line beats.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_araddr_i[4:0], s_awaddr_i[4:0]};

  // ---------------- read channel ----------------
  rd_state_e             rd_state_d, rd_state_q;
  logic [ID_WIDTH-1:0]   rid_d, rid_q;
  logic [3:0]            rlen_d, rlen_q, rbeat_d, rbeat_q;
  logic [LINE_W-1:0]     rline_d, rline_q;
  logic                  rslv_d, rslv_q;
  logic [1:0]            rresp_d, rresp_q;
  logic [CNT_W-1:0]      rcnt_d, rcnt_q;
  logic                  rd_load, slv_src, ar_slv;
  logic [LINE_W-1:0]     ld_line;
  logic [1:0]            ld_resp;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign ar_slv = (s_arsize_i != SIZE_32B) || (s_arburst_i != BURST_INCR);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      rlen_q     <= '0;
      rbeat_q    <= '0;
      rline_q    <= '0;
      rslv_q     <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rcnt_q     <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      rlen_q     <= rlen_d;
      rbeat_q    <= rbeat_d;
      rline_q    <= rline_d;
      rslv_q     <= rslv_d;
      rresp_q    <= rresp_d;
      rcnt_q     <= rcnt_d;
    end
  end

  // ld_line is the line whose data is loaded into the array output register
  // on this edge; the response for that beat is latched alongside it.
  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    rlen_d     = rlen_q;
    rbeat_d    = rbeat_q;
    rline_d    = rline_q;
    rslv_d     = rslv_q;
    rcnt_d     = rcnt_q;
    rd_load    = 1'b0;
    ld_line    = rline_q;
    slv_src    = rslv_q;
    case (rd_state_q)
      R_IDLE: begin
        ld_line = s_araddr_i[ADDR_WIDTH-1:5];
        slv_src = ar_slv;
        if (s_arvalid_i) begin
          rid_d   = s_arid_i;
          rlen_d  = s_arlen_i;
          rline_d = s_araddr_i[ADDR_WIDTH-1:5];
          rslv_d  = ar_slv;
          rbeat_d = '0;
          rcnt_d  = '0;
          if (RD_LAT == 1) begin
            rd_load    = 1'b1;
            rd_state_d = R_DATA;
          end else begin
            rd_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (rcnt_q == WAIT_LAST) begin
          rd_load    = 1'b1;
          rd_state_d = R_DATA;
        end else begin
          rcnt_d = rcnt_q + CNT_W'(1);
        end
      end
      R_DATA: begin
        // Prefetch the next line on the handshake edge so beats stay back-to-back.
        ld_line = rline_q + LINE_W'(1);
        if (s_rready_i) begin
          if (rbeat_q == rlen_q) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_load = 1'b1;
            rline_d = rline_q + LINE_W'(1);
            rbeat_d = rbeat_q + 4'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    ld_resp = resp_merge(slv_src ? RESP_SLVERR : RESP_OKAY, line_resp(ld_line));
    rresp_d = rd_load ? ld_resp : rresp_q;
  end

  always_comb begin
    s_arready_o = (rd_state_q == R_IDLE);
    s_rvalid_o  = (rd_state_q == R_DATA);
    s_rlast_o   = (rd_state_q == R_DATA) && (rbeat_q == rlen_q);
  end

  assign s_rid_o   = rid_q;
  assign s_rresp_o = rresp_q;
  // Error beats never read the array, so mask whatever the register still holds.
  assign s_rdata_o = (rresp_q == RESP_OKAY) ? arr_rdata : '0;

  // ---------------- write channel ----------------
  wr_state_e           wr_state_d, wr_state_q;
  logic [ID_WIDTH-1:0] wid_d, wid_q;
  logic [3:0]          wlen_d, wlen_q, wbeat_d, wbeat_q;
  logic [LINE_W-1:0]   wline_d, wline_q;
  logic                wslv_d, wslv_q;
  logic [1:0]          bresp_d, bresp_q, w_beat_resp;
  logic                mem_we;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_state_q <= W_IDLE;
      wid_q      <= '0;
      wlen_q     <= '0;
      wbeat_q    <= '0;
      wline_q    <= '0;
      wslv_q     <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
      wlen_q     <= wlen_d;
      wbeat_q    <= wbeat_d;
      wline_q    <= wline_d;
      wslv_q     <= wslv_d;
      bresp_q    <= bresp_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wid_d      = wid_q;
    wlen_d     = wlen_q;
    wbeat_d    = wbeat_q;
    wline_d    = wline_q;
    wslv_d     = wslv_q;
    bresp_d    = bresp_q;
    mem_we     = 1'b0;
    // A beat is written only if nothing at all is wrong with it.
    w_beat_resp = resp_merge(
        resp_merge(wslv_q ? RESP_SLVERR : RESP_OKAY, line_resp(wline_q)),
        resp_merge((s_wid_i != wid_q) ? RESP_SLVERR : RESP_OKAY,
                   (s_wlast_i && (wbeat_q != wlen_q)) ? RESP_SLVERR : RESP_OKAY));
    case (wr_state_q)
      W_IDLE: begin
        if (s_awvalid_i) begin
          wid_d      = s_awid_i;
          wlen_d     = s_awlen_i;
          wline_d    = s_awaddr_i[ADDR_WIDTH-1:5];
          wslv_d     = (s_awsize_i != SIZE_32B) || (s_awburst_i != BURST_INCR);
          wbeat_d    = '0;
          bresp_d    = RESP_OKAY;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_wvalid_i) begin
          mem_we  = (w_beat_resp == RESP_OKAY);
          wline_d = wline_q + LINE_W'(1);
          wbeat_d = wbeat_q + 4'd1;
          bresp_d = resp_merge(bresp_q, w_beat_resp);
          if (s_wlast_i) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready_i) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    s_awready_o = (wr_state_q == W_IDLE);
    s_wready_o  = (wr_state_q == W_DATA);
    s_bvalid_o  = (wr_state_q == W_RESP);
  end

  assign s_bid_o   = wid_q;
  assign s_bresp_o = bresp_q;

  bank_slv_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (mem_we),
    .waddr_i (wline_q[IDX_W-1:0]),
    .wdata_i (s_wdata_i),
    .wstrb_i (s_wstrb_i),
    .re_i    (rd_load && (ld_resp == RESP_OKAY)),
    .raddr_i (ld_line[IDX_W-1:0]),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_bank_axi3_slv_mem.sv
// Scoreboard bench for bank_axi3_slv_mem: stimulus pushes expected R beats and
// B responses into queues; a negedge monitor compares whatever the DUT presents.
module tb_bank_axi3_slv_mem;
  import bank_axi3_pkg::*;

  localparam int DEPTH  = 1024;
  localparam int RD_LAT = 2;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         s_arvalid_i, s_arready_o;
  logic [5:0]   s_arid_i;
  logic [31:0]  s_araddr_i;
  logic [3:0]   s_arlen_i;
  logic [2:0]   s_arsize_i;
  logic [1:0]   s_arburst_i;
  logic         s_rvalid_o, s_rready_i;
  logic [5:0]   s_rid_o;
  logic [255:0] s_rdata_o;
  logic [1:0]   s_rresp_o;
  logic         s_rlast_o;
  logic         s_awvalid_i, s_awready_o;
  logic [5:0]   s_awid_i;
  logic [31:0]  s_awaddr_i;
  logic [3:0]   s_awlen_i;
  logic [2:0]   s_awsize_i;
  logic [1:0]   s_awburst_i;
  logic         s_wvalid_i, s_wready_o;
  logic [5:0]   s_wid_i;
  logic [255:0] s_wdata_i;
  logic [31:0]  s_wstrb_i;
  logic         s_wlast_i;
  logic         s_bvalid_o, s_bready_i;
  logic [5:0]   s_bid_o;
  logic [1:0]   s_bresp_o;

  always #5 clk_i = ~clk_i;

  bank_axi3_slv_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(256), .STRB_WIDTH(32), .ID_WIDTH(6),
    .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o), .s_arid_i(s_arid_i),
    .s_araddr_i(s_araddr_i), .s_arlen_i(s_arlen_i), .s_arsize_i(s_arsize_i),
    .s_arburst_i(s_arburst_i), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
    .s_rid_o(s_rid_o), .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rlast_o(s_rlast_o),
    .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o), .s_awid_i(s_awid_i),
    .s_awaddr_i(s_awaddr_i), .s_awlen_i(s_awlen_i), .s_awsize_i(s_awsize_i),
    .s_awburst_i(s_awburst_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
    .s_wid_i(s_wid_i), .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wlast_i(s_wlast_i),
    .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i), .s_bid_o(s_bid_o), .s_bresp_o(s_bresp_o)
  );

  typedef struct {
    logic [5:0]   id;
    logic [255:0] data;
    logic [1:0]   resp;
    logic         last;
  } r_exp_t;

  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t       rq[$];
  b_exp_t       bq[$];
  logic [255:0] mdl [DEPTH];
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic logic [255:0] pat(input int seed);
    logic [255:0] v;
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(seed * 37 + i * 11 + 1);
    return v;
  endfunction

  task automatic mdl_write(input int line, input logic [255:0] data, input logic [31:0] strb);
    for (int b = 0; b < 32; b++)
      if (strb[b]) mdl[line][b*8 +: 8] = data[b*8 +: 8];
  endtask

  // Expected beats for a read: OKAY data from the model, SLVERR for bad
  // size/burst, DECERR past the array top; error beats carry zero data.
  task automatic push_read(input logic [5:0] id, input int line, input int len,
                           input int nbeats, input bit slv);
    r_exp_t e;
    for (int b = 0; b < nbeats; b++) begin
      e.id   = id;
      e.resp = slv ? RESP_SLVERR : RESP_OKAY;
      if (line + b >= DEPTH) e.resp = RESP_DECERR;
      e.data = (e.resp == RESP_OKAY) ? mdl[line + b] : '0;
      e.last = (b == len);
      rq.push_back(e);
    end
  endtask

  task automatic push_b(input logic [5:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id   = id;
    e.resp = resp;
    bq.push_back(e);
  endtask

  // Channel drivers: called at posedge+1, return at posedge+1 after handshake.
  task automatic ar_send(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok = 1'b0;
    int   n = 0;
    s_arvalid_i = 1'b1; s_arid_i = id; s_araddr_i = addr; s_arlen_i = len;
    s_arsize_i = size; s_arburst_i = burst;
    while (!ok && n < 50) begin
      @(negedge clk_i); ok = s_arready_o;
      @(posedge clk_i); n++;
    end
    #1 s_arvalid_i = 1'b0;
    if (!ok) fail_timeout("ar_handshake");
  endtask

  task automatic aw_send(input logic [5:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic ok = 1'b0;
    int   n = 0;
    s_awvalid_i = 1'b1; s_awid_i = id; s_awaddr_i = addr; s_awlen_i = len;
    s_awsize_i = size; s_awburst_i = burst;
    while (!ok && n < 50) begin
      @(negedge clk_i); ok = s_awready_o;
      @(posedge clk_i); n++;
    end
    #1 s_awvalid_i = 1'b0;
    if (!ok) fail_timeout("aw_handshake");
  endtask

  task automatic w_send(input logic [5:0] id, input logic [255:0] data, input logic [31:0] strb,
                        input logic last);
    logic ok = 1'b0;
    int   n = 0;
    s_wvalid_i = 1'b1; s_wid_i = id; s_wdata_i = data; s_wstrb_i = strb; s_wlast_i = last;
    while (!ok && n < 50) begin
      @(negedge clk_i); ok = s_wready_o;
      @(posedge clk_i); n++;
    end
    #1 s_wvalid_i = 1'b0;
    if (!ok) fail_timeout("w_handshake");
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
      @(posedge clk_i); n++;
    end
    if (n >= 200) begin
      fail_timeout("drain");
      rq.delete();
      bq.delete();
    end
    @(posedge clk_i); #1;
  endtask

  // Monitor: compare presented R/B against the queue heads; pop on handshake.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (s_rvalid_o) begin
        if (rq.size() == 0) fail_timeout("r_unexpected_beat");
        else begin
          check("r_id",   s_rid_o,   rq[0].id);
          check("r_data", s_rdata_o, rq[0].data);
          check("r_resp", s_rresp_o, rq[0].resp);
          check("r_last", s_rlast_o, rq[0].last);
          if (s_rready_i) void'(rq.pop_front());
        end
      end
      if (s_bvalid_o) begin
        if (bq.size() == 0) fail_timeout("b_unexpected_resp");
        else begin
          check("b_id",   s_bid_o,   bq[0].id);
          check("b_resp", s_bresp_o, bq[0].resp);
          if (s_bready_i) void'(bq.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    s_arvalid_i = 0; s_arid_i = 0; s_araddr_i = 0; s_arlen_i = 0; s_arsize_i = 0; s_arburst_i = 0;
    s_awvalid_i = 0; s_awid_i = 0; s_awaddr_i = 0; s_awlen_i = 0; s_awsize_i = 0; s_awburst_i = 0;
    s_wvalid_i = 0; s_wid_i = 0; s_wdata_i = 0; s_wstrb_i = 0; s_wlast_i = 0;
    s_rready_i = 1; s_bready_i = 1;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_arready", s_arready_o, 1'b1);
    check("rst_awready", s_awready_o, 1'b1);
    check("rst_rvalid",  s_rvalid_o,  1'b0);
    check("rst_wready",  s_wready_o,  1'b0);
    check("rst_bvalid",  s_bvalid_o,  1'b0);
    check("rst_rlast",   s_rlast_o,   1'b0);
    check("rst_rid",     s_rid_o,     6'd0);
    check("rst_bid",     s_bid_o,     6'd0);
    check("rst_rresp",   s_rresp_o,   2'd0);
    check("rst_bresp",   s_bresp_o,   2'd0);
    check("rst_rdata",   s_rdata_o,   256'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Single-line write to line 0x10, read back with latency check
    aw_send(6'd5, 32'h200, 4'd0, SIZE_32B, BURST_INCR);
    push_b(6'd5, RESP_OKAY);
    w_send(6'd5, pat(1), '1, 1'b1);
    mdl_write(16, pat(1), '1);
    drain();
    push_read(6'd9, 16, 0, 1, 1'b0);
    ar_send(6'd9, 32'h200, 4'd0, SIZE_32B, BURST_INCR);
    @(negedge clk_i); check("r_lat_early",  s_rvalid_o, 1'b0);
    @(negedge clk_i); check("r_lat_ontime", s_rvalid_o, 1'b1);
    drain();

    // Four-beat write of lines 0x20..0x23, then back-to-back read
    aw_send(6'd3, 32'h400, 4'd3, SIZE_32B, BURST_INCR);
    push_b(6'd3, RESP_OKAY);
    for (int i = 0; i < 4; i++) begin
      w_send(6'd3, pat(32 + i), '1, 1'(i == 3));
      mdl_write(32 + i, pat(32 + i), '1);
    end
    drain();
    push_read(6'd11, 32, 3, 4, 1'b0);
    ar_send(6'd11, 32'h400, 4'd3, SIZE_32B, BURST_INCR);
    n = 0;
    do begin @(negedge clk_i); n++; end while (!s_rvalid_o && n < 20);
    if (!s_rvalid_o) fail_timeout("r_first_beat");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); check("r_back_to_back", s_rvalid_o, 1'b1);
    end
    drain();

    // Same read with rready toggling: held beats are checked every cycle
    push_read(6'd12, 32, 3, 4, 1'b0);
    s_rready_i = 1'b0;
    ar_send(6'd12, 32'h400, 4'd3, SIZE_32B, BURST_INCR);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_i); #1 s_rready_i = ~s_rready_i;
    end
    s_rready_i = 1'b1;
    drain();

    // Partial strobe write over line 0x10: only bytes 0..7 change
    aw_send(6'd7, 32'h200, 4'd0, SIZE_32B, BURST_INCR);
    push_b(6'd7, RESP_OKAY);
    w_send(6'd7, pat(2), 32'h0000_00FF, 1'b1);
    mdl_write(16, pat(2), 32'h0000_00FF);
    drain();
    push_read(6'd8, 16, 0, 1, 1'b0);
    ar_send(6'd8, 32'h200, 4'd0, SIZE_32B, BURST_INCR);
    drain();

    // Top of array: prefill lines 0 and DEPTH-1, burst across the top
    aw_send(6'd1, 32'h0, 4'd0, SIZE_32B, BURST_INCR);
    push_b(6'd1, RESP_OKAY);
    w_send(6'd1, pat(3), '1, 1'b1);
    mdl_write(0, pat(3), '1);
    drain();
    aw_send(6'd2, 32'h7FE0, 4'd0, SIZE_32B, BURST_INCR);
    push_b(6'd2, RESP_OKAY);
    w_send(6'd2, pat(4), '1, 1'b1);
    mdl_write(DEPTH - 1, pat(4), '1);
    drain();
    push_read(6'd13, DEPTH - 1, 1, 2, 1'b0);
    ar_send(6'd13, 32'h7FE0, 4'd1, SIZE_32B, BURST_INCR);
    drain();
    aw_send(6'd14, 32'h7FE0, 4'd1, SIZE_32B, BURST_INCR);
    push_b(6'd14, RESP_DECERR);
    w_send(6'd14, pat(5), '1, 1'b0);
    mdl_write(DEPTH - 1, pat(5), '1);
    w_send(6'd14, pat(6), '1, 1'b1);
    drain();
    push_read(6'd15, 0, 0, 1, 1'b0);
    ar_send(6'd15, 32'h0, 4'd0, SIZE_32B, BURST_INCR);
    drain();
    push_read(6'd16, DEPTH - 1, 0, 1, 1'b0);
    ar_send(6'd16, 32'h7FE0, 4'd0, SIZE_32B, BURST_INCR);
    drain();

    // Bad size / bad burst on reads -> SLVERR every beat
    push_read(6'd17, 16, 1, 2, 1'b1);
    ar_send(6'd17, 32'h200, 4'd1, 3'b100, BURST_INCR);
    drain();
    push_read(6'd18, 16, 0, 1, 1'b1);
    ar_send(6'd18, 32'h200, 4'd0, SIZE_32B, 2'b10);
    drain();

    // WID mismatch: SLVERR and line 0x10 left unchanged
    aw_send(6'd4, 32'h200, 4'd0, SIZE_32B, BURST_INCR);
    push_b(6'd4, RESP_SLVERR);
    w_send(6'd5, pat(7), '1, 1'b1);
    drain();
    push_read(6'd19, 16, 0, 1, 1'b0);
    ar_send(6'd19, 32'h200, 4'd0, SIZE_32B, BURST_INCR);
    drain();

    // Early WLAST on beat 0 of a 3-beat burst: SLVERR, FSM returns to idle
    aw_send(6'd20, 32'h600, 4'd2, SIZE_32B, BURST_INCR);
    push_b(6'd20, RESP_SLVERR);
    w_send(6'd20, pat(8), '1, 1'b1);
    drain();
    @(negedge clk_i); check("w_idle_after_early_wlast", s_awready_o, 1'b1);
    @(posedge clk_i); #1;

    // Reset during beat 2 of an 8-beat read
    push_read(6'd21, 32, 7, 3, 1'b0);
    ar_send(6'd21, 32'h400, 4'd7, SIZE_32B, BURST_INCR);
    n = 0;
    while (rq.size() > 1 && n < 40) begin @(posedge clk_i); n++; end
    if (rq.size() > 1) fail_timeout("r_reset_beat2");
    #1 s_rready_i = 1'b0;
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_rvalid", s_rvalid_o, 1'b0);
    check("mid_rst_rlast",  s_rlast_o,  1'b0);
    rq.delete();
    @(posedge clk_i); @(posedge clk_i); #1 rst_i = 1'b0;
    s_rready_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_arready", s_arready_o, 1'b1);
    check("post_rst_rvalid",  s_rvalid_o,  1'b0);
    @(posedge clk_i); #1;
    push_read(6'd22, 16, 0, 1, 1'b0);
    ar_send(6'd22, 32'h200, 4'd0, SIZE_32B, BURST_INCR);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
